// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - state codes, default widths and status helpers for glitch_sequencer
package glitch_pkg;

    localparam int DEF_CNT_W        = 24;
    localparam int DEF_WIDTH_W      = 16;
    localparam int DEF_RESP_TIMEOUT = 2700000;
    localparam int DEF_OFFSET_STEP  = 1;

    localparam logic [5:0] LEDS_OFF = 6'b111111;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_DELAY     = 4'd1;
    localparam state_t ST_GLITCH    = 4'd2;
    localparam state_t ST_SETTLE    = 4'd3;
    localparam state_t ST_SEND      = 4'd4;
    localparam state_t ST_WAIT_TX   = 4'd5;
    localparam state_t ST_WAIT_RESP = 4'd6;
    localparam state_t ST_DONE      = 4'd7;
    localparam state_t ST_FAIL      = 4'd8;

    function automatic logic is_busy_state(input state_t s);
        return !(s == ST_IDLE || s == ST_DONE || s == ST_FAIL);
    endfunction

endpackage

// File: rtl/glitch_down_counter.sv
// rtl/glitch_down_counter.sv - loadable down counter with zero flag, shared by all timed states
module glitch_down_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - one voltage-glitch campaign: delay, power cut, settle, payload, await success
// Optional feature macro GLITCH_SWEEP_EN: each retry steps the captured offset by OFFSET_STEP.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int WIDTH_W      = DEF_WIDTH_W,
    parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT,
    parameter int OFFSET_STEP  = DEF_OFFSET_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cfg_offset,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [CNT_W-1:0]   cfg_settle,
    input  logic [7:0]         cfg_max_attempts,
    output logic               tx_start,
    input  logic               tx_busy,
    input  logic               tx_done,
    input  logic               success,
    output logic               power_tx,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [7:0]         attempt,
    output logic [5:0]         led
);

`ifdef GLITCH_SWEEP_EN
    localparam int SWEEP_STEP = OFFSET_STEP;
`else
    localparam int SWEEP_STEP = 0 * OFFSET_STEP;
`endif

    state_t             state_q, state_d;
    logic               arm_q;
    logic               power_q, power_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, done_q, fail_q;
    logic [5:0]         led_q;
    logic [7:0]         attempt_q, attempt_d;
    logic [7:0]         max_q, max_d;
    logic [CNT_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [WIDTH_W-1:0] width_q, width_d;

    logic               cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0]   cnt_val;
    logic [CNT_W:0]     offset_sum;
    logic [CNT_W-1:0]   offset_next;
    logic [WIDTH_W-1:0] glitch_len;
    logic [CNT_W-1:0]   settle_len;

    glitch_down_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    assign offset_sum  = {1'b0, offset_q} + (CNT_W+1)'(SWEEP_STEP);
    assign offset_next = offset_sum[CNT_W] ? {CNT_W{1'b1}} : offset_sum[CNT_W-1:0];

    // The counter runs until zero inclusive, so load N-1 to get N cycles (minimum 1).
    assign glitch_len = (width_q == '0)  ? '0 : width_q - WIDTH_W'(1);
    assign settle_len = (settle_q == '0) ? '0 : settle_q - CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        power_d    = power_q;
        tx_start_d = tx_start_q;
        attempt_d  = attempt_q;
        max_d      = max_q;
        offset_d   = offset_q;
        settle_d   = settle_q;
        width_d    = width_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_val    = '0;
        if (abort) begin
            state_d    = ST_IDLE;
            power_d    = 1'b1;
            tx_start_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (arm && !arm_q) begin
                    state_d   = ST_DELAY;
                    attempt_d = 8'd1;
                    offset_d  = cfg_offset;
                    width_d   = cfg_width;
                    settle_d  = cfg_settle;
                    max_d     = (cfg_max_attempts == 8'd0) ? 8'd1 : cfg_max_attempts;
                    cnt_load  = 1'b1;
                    cnt_val   = cfg_offset;
                end
                ST_DELAY: if (cnt_zero) begin
                    state_d  = ST_GLITCH;
                    power_d  = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(glitch_len);
                end else cnt_en = 1'b1;
                ST_GLITCH: if (cnt_zero) begin
                    state_d  = ST_SETTLE;
                    power_d  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = settle_len;
                end else cnt_en = 1'b1;
                ST_SETTLE: if (cnt_zero) begin
                    state_d    = ST_SEND;
                    tx_start_d = 1'b1;
                end else cnt_en = 1'b1;
                ST_SEND: if (tx_busy) begin
                    state_d    = ST_WAIT_TX;
                    tx_start_d = 1'b0;
                end
                ST_WAIT_TX: if (tx_done) begin
                    state_d  = ST_WAIT_RESP;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(RESP_TIMEOUT);
                end
                ST_WAIT_RESP: begin
                    if (success) begin
                        state_d = ST_DONE;
                    end else if (cnt_zero) begin
                        if (attempt_q >= max_q) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d   = ST_DELAY;
                            attempt_d = (attempt_q == 8'hFF) ? attempt_q : attempt_q + 8'd1;
                            offset_d  = offset_next;
                            cnt_load  = 1'b1;
                            cnt_val   = offset_next;
                        end
                    end else cnt_en = 1'b1;
                end
                ST_DONE, ST_FAIL: if (!arm) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b0;
            power_q    <= 1'b1;
            tx_start_q <= 1'b0;
            attempt_q  <= 8'd0;
            max_q      <= 8'd1;
            offset_q   <= '0;
            settle_q   <= '0;
            width_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            led_q      <= LEDS_OFF;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm;
            power_q    <= power_d;
            tx_start_q <= tx_start_d;
            attempt_q  <= attempt_d;
            max_q      <= max_d;
            offset_q   <= offset_d;
            settle_q   <= settle_d;
            width_q    <= width_d;
            busy_q     <= is_busy_state(state_d);
            done_q     <= (state_d == ST_DONE);
            fail_q     <= (state_d == ST_FAIL);
            led_q      <= ~{state_d == ST_FAIL, state_d == ST_DONE, state_d};
        end
    end

    assign tx_start = tx_start_q;
    assign power_tx = power_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign attempt  = attempt_q;
    assign led      = led_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - randomized self-checking bench for glitch_sequencer (honours GLITCH_SWEEP_EN)
module tb_glitch_sequencer;

    localparam int CNT_W   = 24;
    localparam int WIDTH_W = 16;
    localparam int T       = 40;
    localparam int STEP    = 5;
`ifdef GLITCH_SWEEP_EN
    localparam int STEP_EXP = STEP;
`else
    localparam int STEP_EXP = 0;
`endif
    localparam logic [5:0] LED_IDLE = 6'b111111;
    localparam logic [5:0] LED_DONE = ~{1'b0, 1'b1, 4'd7};
    localparam logic [5:0] LED_FAIL = ~{1'b1, 1'b0, 4'd8};

    logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, abort = 1'b0;
    logic tx_busy = 1'b0, tx_done = 1'b0, success = 1'b0;
    logic [CNT_W-1:0]   cfg_offset = '0, cfg_settle = '0;
    logic [WIDTH_W-1:0] cfg_width = '0;
    logic [7:0]         cfg_max_attempts = '0;
    logic tx_start, power_tx, busy, done, fail;
    logic [7:0] attempt;
    logic [5:0] led;

    int cyc = 0, checks = 0, errors = 0, falls = 0, starts = 0;
    logic prev_pw = 1'b1, prev_ts = 1'b0;

    glitch_sequencer #(
        .CNT_W(CNT_W), .WIDTH_W(WIDTH_W), .RESP_TIMEOUT(T), .OFFSET_STEP(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .cfg_offset(cfg_offset), .cfg_width(cfg_width), .cfg_settle(cfg_settle),
        .cfg_max_attempts(cfg_max_attempts), .tx_start(tx_start), .tx_busy(tx_busy),
        .tx_done(tx_done), .success(success), .power_tx(power_tx), .busy(busy),
        .done(done), .fail(fail), .attempt(attempt), .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (prev_pw && !power_tx) falls <= falls + 1;
        if (!prev_ts && tx_start) starts <= starts + 1;
        prev_pw <= power_tx;
        prev_ts <= tx_start;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // which: 0 power_tx low, 1 power_tx high, 2 tx_start high; at = -1 when the bound expires
    task automatic wait_for(input int which, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && power_tx === 1'b0) || (which == 1 && power_tx === 1'b1) ||
                (which == 2 && tx_start === 1'b1)) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic start_campaign(input int off, input int w, input int st, input int mx, output int n0);
        @(negedge clk);
        cfg_offset = CNT_W'(off); cfg_width = WIDTH_W'(w);
        cfg_settle = CNT_W'(st);  cfg_max_attempts = 8'(mx);
        arm = 1'b1;
        n0 = cyc + 1;
        @(negedge clk);
        cfg_offset = CNT_W'($urandom); cfg_width = WIDTH_W'($urandom);
        cfg_settle = CNT_W'($urandom); cfg_max_attempts = 8'($urandom);
    endtask

    // UART engine model: called at the negedge tx_start was first seen high
    task automatic serve_tx(input int busy_dly, input int done_dly, output int ed, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < busy_dly; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b1) ok = 1'b0;
        end
        tx_busy = 1'b1;
        @(negedge clk);
        if (tx_start !== 1'b0) ok = 1'b0;
        tx_busy = 1'b0;
        repeat (done_dly) @(negedge clk);
        tx_done = 1'b1;
        ed = cyc + 1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({power_tx, tx_start, busy, done, fail, attempt, led} !== {5'b10000, 8'd0, LED_IDLE}) begin
            errors++;
            $display("FAIL reset_in: got %b exp %b", {power_tx, tx_start, busy, done, fail, attempt, led}, {5'b10000, 8'd0, LED_IDLE});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({power_tx, tx_start, busy, done, fail, attempt, led} !== {5'b10000, 8'd0, LED_IDLE}) begin
            errors++;
            $display("FAIL reset_out: got %b exp %b", {power_tx, tx_start, busy, done, fail, attempt, led}, {5'b10000, 8'd0, LED_IDLE});
        end
    endtask

    task automatic test_basic();
        int off, w, st, n0, t1, t2, t3, ed;
        bit ok;
        for (int it = 0; it < 3; it++) begin
            off = (it == 0) ? 100 : $urandom_range(1, 150);
            w   = (it == 0) ? 4 : $urandom_range(1, 9);
            st  = (it == 0) ? 10 : $urandom_range(0, 12);
            success = 1'b1;
            start_campaign(off, w, st, 1, n0);
            wait_for(0, off + 10, t1);
            checks++;
            if (t1 !== n0 + off + 1) begin errors++; $display("FAIL basic_cut_time: got %0d exp %0d", t1, n0 + off + 1); end
            wait_for(1, w + 5, t2);
            checks++;
            if (t2 - t1 !== w) begin errors++; $display("FAIL basic_cut_width: got %0d exp %0d", t2 - t1, w); end
            wait_for(2, st + 5, t3);
            checks++;
            if (t3 !== t2 + ((st == 0) ? 1 : st)) begin errors++; $display("FAIL basic_settle: got %0d exp %0d", t3, t2 + ((st == 0) ? 1 : st)); end
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL basic_early_success: done got %b exp 0", done); end
            success = 1'b0;
            serve_tx($urandom_range(0, 3), $urandom_range(0, 4), ed, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL basic_tx_handshake: got 0 exp 1"); end
            repeat ($urandom_range(0, T - 1)) @(negedge clk);
            success = 1'b1;
            @(negedge clk);
            success = 1'b0;
            checks++;
            if ({done, fail, busy, attempt, led} !== {3'b100, 8'd1, LED_DONE}) begin
                errors++; $display("FAIL basic_done: got %b exp %b", {done, fail, busy, attempt, led}, {3'b100, 8'd1, LED_DONE});
            end
            arm = 1'b0;
            @(negedge clk);
            checks++;
            if ({done, busy, led} !== {2'b00, LED_IDLE}) begin
                errors++; $display("FAIL basic_idle: got %b exp %b", {done, busy, led}, {2'b00, LED_IDLE});
            end
        end
    endtask

    task automatic test_min_width();
        int st, n0, t1, t2, t3, ed;
        bit ok;
        st = $urandom_range(0, 5);
        start_campaign(0, 0, st, 1, n0);
        wait_for(0, 5, t1);
        checks++;
        if (t1 !== n0 + 1) begin errors++; $display("FAIL min_cut_time: got %0d exp %0d", t1, n0 + 1); end
        wait_for(1, 5, t2);
        checks++;
        if (t2 - t1 !== 1) begin errors++; $display("FAIL min_cut_width: got %0d exp 1", t2 - t1); end
        wait_for(2, st + 5, t3);
        checks++;
        if (t3 !== t2 + ((st == 0) ? 1 : st)) begin errors++; $display("FAIL min_settle: got %0d exp %0d", t3, t2 + ((st == 0) ? 1 : st)); end
        serve_tx(3, 2, ed, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL min_tx_start_hold_drop: got 0 exp 1"); end
        success = 1'b1;
        @(negedge clk);
        success = 1'b0;
        checks++;
        if ({done, power_tx} !== 2'b11) begin errors++; $display("FAIL min_done: got %b exp 11", {done, power_tx}); end
        arm = 1'b0;
        @(negedge clk);
    endtask

    // Success is raised in WAIT_RESP of attempt win (1-based); win = 0 means never
    task automatic test_retry(input int mx, input int win);
        int n, off, w, st, n0, t, ed, next_d, exp_t, f0, s0;
        bit ok;
        n   = (win != 0) ? win : ((mx == 0) ? 1 : mx);
        off = $urandom_range(10, 60);
        w   = $urandom_range(1, 5);
        st  = $urandom_range(0, 6);
        f0 = falls; s0 = starts;
        start_campaign(off, w, st, mx, n0);
        next_d = n0;
        ed = n0;
        for (int k = 0; k < n; k++) begin
            exp_t = next_d + off + k * STEP_EXP + 1;
            wait_for(0, off + k * STEP_EXP + T + 10, t);
            checks++;
            if (t !== exp_t) begin errors++; $display("FAIL retry_cut_time[%0d]: got %0d exp %0d", k, t, exp_t); end
            checks++;
            if (attempt !== 8'(k + 1)) begin errors++; $display("FAIL retry_attempt[%0d]: got %0d exp %0d", k, attempt, k + 1); end
            wait_for(2, w + st + 10, t);
            serve_tx($urandom_range(0, 2), $urandom_range(0, 3), ed, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL retry_tx[%0d]: got 0 exp 1", k); end
            next_d = ed + T + 1;
        end
        if (win != 0) begin
            repeat ($urandom_range(0, T - 1)) @(negedge clk);
            success = 1'b1;
            @(negedge clk);
            success = 1'b0;
            checks++;
            if ({done, fail, attempt} !== {2'b10, 8'(win)}) begin
                errors++; $display("FAIL retry_success: got %b exp %b", {done, fail, attempt}, {2'b10, 8'(win)});
            end
        end else begin
            repeat (ed + T - cyc) @(negedge clk);
            checks++;
            if ({fail, busy} !== 2'b01) begin errors++; $display("FAIL retry_pre_fail: got %b exp 01", {fail, busy}); end
            @(negedge clk);
            checks++;
            if ({fail, power_tx, attempt, led} !== {2'b11, 8'(n), LED_FAIL}) begin
                errors++; $display("FAIL retry_fail: got %b exp %b", {fail, power_tx, attempt, led}, {2'b11, 8'(n), LED_FAIL});
            end
        end
        repeat (off + n * STEP_EXP + T + 20) @(negedge clk);
        checks++;
        if ((falls - f0 !== n) || (starts - s0 !== n)) begin
            errors++; $display("FAIL retry_pulse_count: got %0d/%0d exp %0d", falls - f0, starts - s0, n);
        end
        arm = 1'b0;
        @(negedge clk);
        checks++;
        if ({fail, done, busy, led} !== {3'b000, LED_IDLE}) begin
            errors++; $display("FAIL retry_idle: got %b exp %b", {fail, done, busy, led}, {3'b000, LED_IDLE});
        end
    endtask

    task automatic test_abort();
        int off, n0, t, f0, s0;
        off = $urandom_range(5, 30);
        start_campaign(off, 12, 3, 1, n0);
        wait_for(0, off + 10, t);
        checks++;
        if (t !== n0 + off + 1) begin errors++; $display("FAIL abort_cut_time: got %0d exp %0d", t, n0 + off + 1); end
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({power_tx, busy, tx_start, led, attempt} !== {3'b100, LED_IDLE, 8'd1}) begin
            errors++; $display("FAIL abort_glitch: got %b exp %b", {power_tx, busy, tx_start, led, attempt}, {3'b100, LED_IDLE, 8'd1});
        end
        f0 = falls; s0 = starts;
        repeat (40) @(negedge clk);
        checks++;
        if ((falls !== f0) || (starts !== s0) || (busy !== 1'b0)) begin
            errors++; $display("FAIL abort_quiet: got falls %0d starts %0d exp %0d %0d", falls, starts, f0, s0);
        end
        arm = 1'b0;
        @(negedge clk);
        arm = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (off + 10) @(negedge clk);
        checks++;
        if ((falls !== f0) || (busy !== 1'b0) || (power_tx !== 1'b1)) begin
            errors++; $display("FAIL abort_same_cycle_arm: got falls %0d busy %b exp %0d 0", falls, busy, f0);
        end
        arm = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_width();
        test_retry(3, 0);
        test_retry(0, 0);
        test_retry(5, 2);
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
